// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: length codes, requester indices and request bundle.
// Request address/data fields are sized for the widest supported AW/DW (64) and truncated at the memory side.
package dmem_pkg;

    localparam logic [1:0] LEN_NONE = 2'b00;
    localparam logic [1:0] LEN_BYTE = 2'b01;
    localparam logic [1:0] LEN_HALF = 2'b10;
    localparam logic [1:0] LEN_WORD = 2'b11;

    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_LDR = 1;

    localparam int unsigned REQ_AW_MAX = 64;
    localparam int unsigned REQ_DW_MAX = 64;

    typedef struct packed {
        logic                  we;
        logic [1:0]            len;
        logic                  is_signed;
        logic [REQ_AW_MAX-1:0] addr;
        logic [REQ_DW_MAX-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arb_resp.sv
// Per-port load return register: captures memory read data on a load grant, pulses rvalid next cycle.
module dmem_arb_resp #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          capture,
    input  logic [DW-1:0] mem_rdata,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= capture;
            if (capture) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port DATA_MEMORY arbiter: CPU (port 0) has fixed priority, loader (port 1) is forced after STARVE_LIMIT denials.
// Optional macro DMEM_ARB_LOCK_EN adds p1_lock for atomic loader sequences.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32
) (
    input  logic          SYS_clk,
    input  logic          SYS_reset_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [1:0]    p0_len,
    input  logic          p0_signed,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [1:0]    p1_len,
    input  logic          p1_signed,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic          p1_lock,
`endif
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          cpu_stall,
    output logic [1:0]    MEM_write_length,
    output logic [AW-1:0] MEM_write_address,
    output logic [DW-1:0] MEM_write_data,
    output logic [1:0]    MEM_read_length,
    output logic          MEM_read_signed,
    output logic [AW-1:0] MEM_read_address,
    input  logic [DW-1:0] MEM_read_data
);

    dmem_req_t  req0, req1, sel;
    logic [1:0] gnt;
    logic [3:0] starve_cnt;
    logic       force1;
    logic       hold1;
    logic       unused_sel;

    assign req0 = '{we: p0_we, len: p0_len, is_signed: p0_signed,
                    addr: REQ_AW_MAX'(p0_addr), wdata: REQ_DW_MAX'(p0_wdata)};
    assign req1 = '{we: p1_we, len: p1_len, is_signed: p1_signed,
                    addr: REQ_AW_MAX'(p1_addr), wdata: REQ_DW_MAX'(p1_wdata)};

`ifdef DMEM_ARB_LOCK_EN
    logic lock_owner;

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            lock_owner <= 1'b0;
        end else if (p1_gnt && p1_lock) begin
            lock_owner <= 1'b1;
        end else if ((p1_gnt && !p1_lock) || !p1_req) begin
            lock_owner <= 1'b0;
        end
    end

    assign hold1 = lock_owner;
`else
    assign hold1 = 1'b0;
`endif

    assign force1 = (starve_cnt == 4'(STARVE_LIMIT));

    // A held lock also keeps the loader granted over a pending CPU request.
    assign gnt[PORT_LDR] = SYS_reset_n & p1_req & (~p0_req | force1 | hold1);
    assign gnt[PORT_CPU] = SYS_reset_n & p0_req & ~gnt[PORT_LDR] & ~hold1;
    assign p0_gnt        = gnt[PORT_CPU];
    assign p1_gnt        = gnt[PORT_LDR];
    assign cpu_stall     = p0_req & ~p0_gnt;

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            starve_cnt <= '0;
        end else if (p1_gnt || !p1_req) begin
            starve_cnt <= '0;
        end else if (!force1) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign sel        = gnt[PORT_LDR] ? req1 : req0;
    assign unused_sel = ^{sel.addr, sel.wdata};

    always_comb begin
        MEM_write_length  = LEN_NONE;
        MEM_write_address = '0;
        MEM_write_data    = '0;
        MEM_read_length   = LEN_WORD;
        MEM_read_signed   = 1'b0;
        MEM_read_address  = '0;
        if (|gnt) begin
            if (sel.we) begin
                MEM_write_length  = sel.len;
                MEM_write_address = sel.addr[AW-1:0];
                MEM_write_data    = sel.wdata[DW-1:0];
            end else begin
                MEM_read_length   = sel.len;
                MEM_read_signed   = sel.is_signed;
                MEM_read_address  = sel.addr[AW-1:0];
            end
        end
    end

    dmem_arb_resp #(.DW(DW)) u_resp0 (
        .clk       (SYS_clk),
        .rst_n     (SYS_reset_n),
        .capture   (p0_gnt & ~p0_we),
        .mem_rdata (MEM_read_data),
        .rvalid    (p0_rvalid),
        .rdata     (p0_rdata)
    );

    dmem_arb_resp #(.DW(DW)) u_resp1 (
        .clk       (SYS_clk),
        .rst_n     (SYS_reset_n),
        .capture   (p1_gnt & ~p1_we),
        .mem_rdata (MEM_read_data),
        .rvalid    (p1_rvalid),
        .rdata     (p1_rdata)
    );

endmodule
